// File: rtl/alu_rr_arbiter_if.sv
// Handshake bundle between two requesters, a result consumer and the shared-ALU arbiter.
// Signal suffixes are written from the arbiter's point of view.
interface alu_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [WIDTH-1:0] req0_first_i;
  logic [WIDTH-1:0] req0_second_i;
  logic [2:0]       req0_opcode_i;
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [WIDTH-1:0] req1_first_i;
  logic [WIDTH-1:0] req1_second_i;
  logic [2:0]       req1_opcode_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_id_o;
  logic [WIDTH-1:0] rsp_data_o;
  logic             busy_o;

  // Requesters and result consumer.
  modport master (
    output req0_valid_i, req0_first_i, req0_second_i, req0_opcode_i,
    output req1_valid_i, req1_first_i, req1_second_i, req1_opcode_i,
    output rsp_ready_i,
    input  req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
  );

  // Arbiter side.
  modport slave (
    input  req0_valid_i, req0_first_i, req0_second_i, req0_opcode_i,
    input  req1_valid_i, req1_first_i, req1_second_i, req1_opcode_i,
    input  rsp_ready_i,
    output req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, busy_o
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (evaluate) -> RESP (hold until taken).
module alu_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  alu_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [WIDTH:0] WidthVal = (WIDTH + 1)'(WIDTH);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [2:0]       opcode_q, opcode_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             gnt0, gnt1;
  logic [WIDTH-1:0] alu_res;

  // Grant only in IDLE; under contention the pointer picks the winner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StIdle) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = bus.req0_valid_i;
        gnt1 = bus.req1_valid_i;
      end
    end
  end

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;

  // ALU evaluated on captured operands; carries are dropped.
  always_comb begin
    alu_res = '0;
    unique case (opcode_q)
      3'b000: alu_res = ~(op_a_q | op_b_q);
      3'b001: alu_res = op_a_q & op_b_q;
      3'b010: alu_res = op_a_q + op_b_q;
      3'b011: alu_res = op_a_q + op_b_q;
      3'b100: alu_res = ~op_b_q;
      3'b101: alu_res = ~(op_a_q ^ op_b_q);
      3'b110: alu_res = {WIDTH{op_a_q == op_b_q}};
      3'b111: alu_res = ({1'b0, op_b_q} >= WidthVal) ? '0 : (op_a_q >> op_b_q);
      default: alu_res = '0;
    endcase
  end

  // Next-state: capture on grant, register result in EXEC, hold until consumer takes it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opcode_d    = opcode_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0 || gnt1) begin
          op_a_d   = gnt1 ? bus.req1_first_i  : bus.req0_first_i;
          op_b_d   = gnt1 ? bus.req1_second_i : bus.req0_second_i;
          opcode_d = gnt1 ? bus.req1_opcode_i : bus.req0_opcode_i;
          id_d     = gnt1;
          // Pointer always moves to the requester that was not served.
          ptr_d    = gnt0;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = alu_res;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opcode_q    <= opcode_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.busy_o      = (state_q != StIdle);

endmodule
